// File: rtl/ifetch_queue_if.sv
// Fetch-queue bus bundle: redirect input, instruction-memory handshake and decode-side queue head.
// fetch_err exists only when IFETCH_MISALIGN_CHK_EN is defined.
interface ifetch_queue_if;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr_data;
  logic [31:0] instr_pc;
  logic        instr_ready;
`ifdef IFETCH_MISALIGN_CHK_EN
  logic        fetch_err;
`endif

  modport master (
`ifdef IFETCH_MISALIGN_CHK_EN
    output fetch_err,
`endif
    input  redirect, redirect_pc, imem_gnt, imem_rvalid, imem_rdata, instr_ready,
    output imem_req, imem_addr, instr_valid, instr_data, instr_pc
  );

  modport slave (
`ifdef IFETCH_MISALIGN_CHK_EN
    input  fetch_err,
`endif
    output redirect, redirect_pc, imem_gnt, imem_rvalid, imem_rdata, instr_ready,
    input  imem_req, imem_addr, instr_valid, instr_data, instr_pc
  );
endinterface

// File: rtl/ifetch_queue.sv
// Instruction fetch queue: one outstanding imem request, DEPTH-entry FIFO, redirect flush.
// Optional IFETCH_MISALIGN_CHK_EN adds a sticky fetch_err on misaligned redirect targets.
module ifetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic          clk,
  input  logic          reset,
  ifetch_queue_if.master bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {RUN, WAIT, DROP} state_e;

  state_e                   state_q, state_d;
  logic [31:0]              fetch_pc_q, fetch_pc_d;
  logic [31:0]              req_pc_q, req_pc_d;
  logic [CW-1:0]            count_q, count_d;
  logic [AW-1:0]            wptr_q, wptr_d, rptr_q, rptr_d;
  logic [DEPTH-1:0][31:0]   data_q, pc_q;
  logic [31:0]              redir_pc;
  logic                     req_blk;
  logic                     req, push, pop, valid, fire;

`ifdef IFETCH_MISALIGN_CHK_EN
  logic err_q, err_d;
  assign redir_pc      = bus.redirect_pc;
  assign err_d         = err_q | (bus.redirect && (redir_pc[1:0] != 2'b00));
  assign req_blk       = err_q;
  assign bus.fetch_err = err_q;

  always_ff @(posedge clk) begin
    if (reset) err_q <= 1'b0;
    else       err_q <= err_d;
  end
`else
  logic unused_pc_lsb;
  assign redir_pc      = {bus.redirect_pc[31:2], 2'b00};
  assign unused_pc_lsb = ^bus.redirect_pc[1:0];
  assign req_blk       = 1'b0;
`endif

  assign valid           = (count_q != '0) && !bus.redirect && !reset;
  assign pop             = valid && bus.instr_ready;
  assign bus.instr_valid = valid;
  assign bus.instr_data  = data_q[rptr_q];
  assign bus.instr_pc    = pc_q[rptr_q];
  assign bus.imem_req    = req;
  assign bus.imem_addr   = fetch_pc_q;
  assign fire            = req && bus.imem_gnt;

  always_comb begin
    req  = 1'b0;
    push = 1'b0;
    case (state_q)
      RUN:  req = count_q < CW'(DEPTH);
      WAIT: if (bus.imem_rvalid) begin
        push = 1'b1;
        // a response never lands on a full queue, so count+1 cannot overflow CW bits
        req  = (count_q + CW'(1) - CW'(pop)) < CW'(DEPTH);
      end
      default: ;
    endcase
    if (reset || bus.redirect || req_blk) req  = 1'b0;
    if (bus.redirect)                     push = 1'b0;
  end

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    if (bus.redirect) begin
      fetch_pc_d = redir_pc;
      if (state_q != RUN && !bus.imem_rvalid) state_d = DROP;
      else                                    state_d = RUN;
    end else begin
      case (state_q)
        RUN:     if (fire) state_d = WAIT;
        WAIT:    if (bus.imem_rvalid) state_d = fire ? WAIT : RUN;
        DROP:    if (bus.imem_rvalid) state_d = RUN;
        default: state_d = RUN;
      endcase
      if (fire) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
        req_pc_d   = fetch_pc_q;
      end
    end
  end

  always_comb begin
    count_d = count_q + CW'(push) - CW'(pop);
    wptr_d  = wptr_q + AW'(push);
    rptr_d  = rptr_q + AW'(pop);
    if (bus.redirect) begin
      count_d = '0;
      wptr_d  = '0;
      rptr_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= RUN;
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= '0;
      count_q    <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      data_q     <= '0;
      pc_q       <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
      count_q    <= count_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      if (push) begin
        data_q[wptr_q] <= bus.imem_rdata;
        pc_q[wptr_q]   <= req_pc_q;
      end
    end
  end
endmodule

// File: tb/tb_ifetch_queue.sv
// Randomized bench for ifetch_queue: queue-level reference model plus directed pins.
module tb_ifetch_queue;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ifetch_queue_if bus();
  ifetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (.clk(clk), .reset(reset), .bus(bus));

  // reference model: fetch pointer, one outstanding request flag, queue of {data,pc}
  logic [31:0] m_pc, m_lpc;
  bit          m_out, m_drop, m_err, m_zero;
  logic [63:0] mq[$];
  logic [31:0] popped[$], gnt_addrs[$];
  int          n_gnt;

  bit mem_busy;
  int mem_dly;
  int p_gnt, p_ready, min_lat, max_lat;
  bit allow_same;

  int n_chk, n_pass;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [31:0] qget(input logic [31:0] q[$], input int i);
    return (q.size() > i) ? q[i] : 32'hDEAD_BEEF;
  endfunction

  task automatic cycle(input bit rst, input bit redir, input logic [31:0] rpc);
    bit rv, g, rdy, valid, pop, req;
    logic [31:0] rd, rpc_e;
    @(negedge clk);
    rv  = mem_busy && (mem_dly == 0);
    g   = ($urandom_range(99) < p_gnt) && (!mem_busy || (allow_same && rv));
    rdy = $urandom_range(99) < p_ready;
    rd  = $urandom;
    reset           = rst;
    bus.redirect    = redir;
    bus.redirect_pc = rpc;
    bus.imem_gnt    = g;
    bus.imem_rvalid = rv;
    bus.imem_rdata  = rd;
    bus.instr_ready = rdy;
`ifdef IFETCH_MISALIGN_CHK_EN
    rpc_e = rpc;
`else
    rpc_e = {rpc[31:2], 2'b00};
`endif
    #1;
    valid = !rst && !redir && (mq.size() != 0);
    pop   = valid && rdy;
    req   = !rst && !redir && !m_err &&
            (m_out ? (!m_drop && rv && (mq.size() + 1 - int'(pop) < DEPTH))
                   : (mq.size() < DEPTH));
    chk("instr_valid", 32'(bus.instr_valid), 32'(valid));
    chk("imem_req", 32'(bus.imem_req), 32'(req));
    if (req) chk("imem_addr", bus.imem_addr, m_pc);
    if (valid) begin
      chk("instr_pc", bus.instr_pc, mq[0][31:0]);
      chk("instr_data", bus.instr_data, mq[0][63:32]);
    end else if (m_zero) begin
      chk("zero_pc", bus.instr_pc, 32'h0);
      chk("zero_data", bus.instr_data, 32'h0);
    end
`ifdef IFETCH_MISALIGN_CHK_EN
    chk("fetch_err", 32'(bus.fetch_err), 32'(m_err));
`endif
    @(posedge clk);
    if (rst) begin
      m_pc = RESET_PC; mq.delete(); m_out = 0; m_drop = 0; m_err = 0; m_zero = 1;
    end else begin
      if (pop) begin
        popped.push_back(mq[0][31:0]);
        void'(mq.pop_front());
      end
      if (redir) begin
        mq.delete();
        m_pc = rpc_e;
`ifdef IFETCH_MISALIGN_CHK_EN
        if (rpc_e[1:0] != 2'b00) m_err = 1;
`endif
        if (m_out && !rv) m_drop = 1;
        else begin m_out = 0; m_drop = 0; end
      end else begin
        if (m_out && rv) begin
          if (!m_drop) begin mq.push_back({rd, m_lpc}); m_zero = 0; end
          m_out = 0; m_drop = 0;
        end
        if (req && g) begin
          m_out = 1; m_lpc = m_pc; gnt_addrs.push_back(m_pc); m_pc += 32'd4; n_gnt++;
        end
      end
    end
    if (rv) mem_busy = 0;
    if (req && g) begin mem_busy = 1; mem_dly = $urandom_range(max_lat, min_lat); end
    else if (mem_busy) mem_dly--;
  endtask

  task automatic knobs(input int pg, input int pr, input int lo, input int hi, input bit same);
    p_gnt = pg; p_ready = pr; min_lat = lo; max_lat = hi; allow_same = same;
  endtask

  task automatic do_reset();
    cycle(1, 0, 0);
    cycle(1, 0, 0);
    popped.delete(); gnt_addrs.delete(); n_gnt = 0;
  endtask

  initial begin
    int base;
    logic [31:0] rpc;
    reset = 1'b1; bus.redirect = 0; bus.redirect_pc = 0; bus.imem_gnt = 0;
    bus.imem_rvalid = 0; bus.imem_rdata = 0; bus.instr_ready = 0;
    m_zero = 0; m_err = 0; m_out = 0; m_drop = 0; mq.delete();
    knobs(100, 100, 0, 0, 0);

    // sequential fetch, memory answers next cycle and only grants when idle
    do_reset();
    #1 chk("rst_addr", bus.imem_addr, RESET_PC);
    for (int i = 0; i < 20; i++) cycle(0, 0, 0);
    base = popped.size();
    for (int i = 0; i < 20; i++) cycle(0, 0, 0);
    chk("steady_pops", 32'(popped.size() - base), 32'd10);
    chk("seq_pc0", qget(popped, 0), 32'h0);
    chk("seq_pc1", qget(popped, 1), 32'h4);
    chk("seq_pc2", qget(popped, 2), 32'h8);
    chk("seq_pc3", qget(popped, 3), 32'hC);

    // full backpressure
    knobs(100, 0, 0, 0, 1);
    do_reset();
    for (int i = 0; i < 15; i++) cycle(0, 0, 0);
    chk("full_grants", 32'(n_gnt), 32'd4);
    chk("full_entries", 32'(mq.size()), 32'd4);
    p_ready = 100; cycle(0, 0, 0);
    p_ready = 0;   cycle(0, 0, 0);
    chk("resume_grant", 32'(n_gnt), 32'd5);

    // redirect while waiting, response two cycles later is dropped
    knobs(100, 100, 2, 2, 0);
    do_reset();
    cycle(0, 0, 0);
    cycle(0, 1, 32'h100);
    popped.delete(); gnt_addrs.delete();
    for (int i = 0; i < 12; i++) cycle(0, 0, 0);
    chk("drop_gnt_addr", qget(gnt_addrs, 0), 32'h100);
    chk("drop_first_pc", qget(popped, 0), 32'h100);

    // redirect together with rvalid and decode ready
    knobs(100, 0, 0, 0, 0);
    do_reset();
    cycle(0, 0, 0); cycle(0, 0, 0); cycle(0, 0, 0);
    gnt_addrs.delete();
    p_ready = 100;
    cycle(0, 1, 32'h200);
    chk("redir_rv_count", 32'(mq.size()), 32'd0);
    #1 chk("redir_rv_valid", 32'(bus.instr_valid), 32'd0);
    for (int i = 0; i < 4; i++) cycle(0, 0, 0);
    chk("redir_rv_addr", qget(gnt_addrs, 0), 32'h200);

    // reset while waiting, late response ignored
    knobs(100, 100, 1, 1, 1);
    do_reset();
    cycle(0, 0, 0);
    cycle(1, 0, 0);
    popped.delete(); gnt_addrs.delete();
    for (int i = 0; i < 8; i++) cycle(0, 0, 0);
    chk("late_rv_addr", qget(gnt_addrs, 0), RESET_PC);
    chk("late_rv_pc", qget(popped, 0), RESET_PC);

    // fetch_pc wraps at 2^32
    knobs(100, 100, 0, 0, 1);
    do_reset();
    cycle(0, 1, 32'hFFFF_FFFC);
    gnt_addrs.delete();
    for (int i = 0; i < 6; i++) cycle(0, 0, 0);
    chk("wrap_a0", qget(gnt_addrs, 0), 32'hFFFF_FFFC);
    chk("wrap_a1", qget(gnt_addrs, 1), 32'h0);

`ifdef IFETCH_MISALIGN_CHK_EN
    do_reset();
    cycle(0, 1, 32'h102);
    #1 chk("err_set", 32'(bus.fetch_err), 32'd1);
    n_gnt = 0;
    for (int i = 0; i < 10; i++) cycle(0, 0, 0);
    chk("err_no_grant", 32'(n_gnt), 32'd0);
    do_reset();
    #1 chk("err_clear", 32'(bus.fetch_err), 32'd0);
`endif

    // randomized traffic with occasional redirects and resets
    do_reset();
    for (int ph = 0; ph < 4; ph++) begin
      case (ph)
        0: knobs(70, 60, 0, 2, 1);
        1: knobs(40, 90, 0, 3, 1);
        2: knobs(100, 20, 0, 0, 1);
        default: knobs(85, 50, 0, 1, 0);
      endcase
      for (int i = 0; i < 600; i++) begin
        bit r_rst, r_red;
        r_rst = $urandom_range(99) < 1;
        r_red = !r_rst && ($urandom_range(99) < 4);
        rpc = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 + ($urandom_range(3) << 2)) : $urandom;
`ifdef IFETCH_MISALIGN_CHK_EN
        rpc[1:0] = 2'b00;
`endif
        cycle(r_rst, r_red, rpc);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
